// File: rtl/ksa2_tester_pkg.sv
// Shared definitions for the KSA2 pulse tester.
//   state_t         controller states
//   LFSR_TAPS       feedback mask for x^8+x^6+x^5+x^4+1 (shift-left Fibonacci form)
//   LFSR_SEED_DEFAULT  nonzero seed loaded on reset and on every accepted start
//   ksa2_golden     reference sum {cout,sum1,sum0} for one operand vector
//   lfsr_next       one LFSR step
package ksa2_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    function automatic logic [2:0] ksa2_golden(input logic [1:0] a,
                                               input logic [1:0] b,
                                               input logic       cin);
        return {1'b0, a} + {1'b0, b} + {2'b00, cin};
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ksa2_vec_gen.sv
// Operand vector source for the KSA2 pulse tester.
// Ports:
//   GCLK, RST  clock, async active-high reset
//   load       restart both sources (counter to 0, LFSR to SEED)
//   step       advance both sources by one vector
//   mode       0 = exhaustive counter, 1 = LFSR
//   vec        {cin,b1,b0,a1,a0} for the current vector
module ksa2_vec_gen
    import ksa2_tester_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       GCLK,
    input  logic       RST,
    input  logic       load,
    input  logic       step,
    input  logic       mode,
    output logic [4:0] vec
);

    logic [4:0] cnt;
    logic [7:0] lfsr;

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (load) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (step) begin
            cnt  <= cnt + 5'd1;
            lfsr <= lfsr_next(lfsr);
        end
    end

    // 5-bit counter wraps naturally, giving the mod-32 exhaustive pattern.
    assign vec = mode ? lfsr[4:0] : cnt;

endmodule

// File: rtl/ksa2_pulse_tester.sv
// Driver/checker for the 2-bit Kogge-Stone adder pads.
// Launches one operand vector per GCLK cycle, aligns golden results to the
// adder's pipeline depth and reports pass/fail, error count and first failure.
// Ports:
//   GCLK, RST                  clock, async active-high reset
//   start, mode, num_vec       run request; mode/num_vec sampled on accept
//   a0/a1/b0/b1/cin_Pad        registered stimulus to the adder
//   sum0/sum1/cout_Pad         adder response, sampled on GCLK
//   busy, done, pass           run status (done is a one-cycle pulse)
//   err_count                  mismatching vectors, saturating at 255
//   first_err_idx/got/exp      index, received and expected value of first mismatch
//
// state    | meaning
// ST_IDLE  | waiting for start after reset
// ST_RUN   | launching vectors, one per cycle
// ST_DRAIN | pads at 0, waiting for the last response to be compared
// ST_DONE  | results held until the next start
module ksa2_pulse_tester
    import ksa2_tester_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter int         NVEC_W    = 8,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic              GCLK,
    input  logic              RST,
    input  logic              start,
    input  logic              mode,
    input  logic [NVEC_W-1:0] num_vec,
    output logic              a0_Pad,
    output logic              a1_Pad,
    output logic              b0_Pad,
    output logic              b1_Pad,
    output logic              cin_Pad,
    input  logic              sum0_Pad,
    input  logic              sum1_Pad,
    input  logic              cout_Pad,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [NVEC_W-1:0] first_err_idx,
    output logic [2:0]        first_err_got,
    output logic [2:0]        first_err_exp
);

    localparam int DRAIN_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              vld;
        logic [NVEC_W-1:0] vidx;
        logic [2:0]        gold;
    } exp_t;

    state_t             state;
    logic               mode_q;
    logic [NVEC_W-1:0]  num_vec_q;
    logic [NVEC_W-1:0]  idx;
    logic [DRAIN_W-1:0] drain_cnt;

    // pipe[0] is loaded on the same edge as the pad registers, so it tracks the
    // vector currently on the pads; pipe[DEPTH] lines up with the response
    // being sampled at this edge.
    exp_t pipe [DEPTH+1];

    logic [4:0] vec;
    logic       accept;
    logic       mismatch;
    logic [2:0] resp;
    logic [7:0] err_next;

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign resp     = {cout_Pad, sum1_Pad, sum0_Pad};
    assign mismatch = pipe[DEPTH].vld && (resp != pipe[DEPTH].gold);
    assign err_next = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

    ksa2_vec_gen #(
        .SEED (LFSR_SEED)
    ) u_vec_gen (
        .GCLK (GCLK),
        .RST  (RST),
        .load (accept),
        .step (state == ST_RUN),
        .mode (mode_q),
        .vec  (vec)
    );

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            mode_q        <= 1'b0;
            num_vec_q     <= '0;
            idx           <= '0;
            drain_cnt     <= '0;
            {cin_Pad, b1_Pad, b0_Pad, a1_Pad, a0_Pad} <= '0;
            for (int i = 0; i <= DEPTH; i++) pipe[i] <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else begin
            done <= 1'b0;

            for (int i = 1; i <= DEPTH; i++) pipe[i] <= pipe[i-1];
            if (state == ST_RUN) begin
                {cin_Pad, b1_Pad, b0_Pad, a1_Pad, a0_Pad} <= vec;
                pipe[0] <= '{vld: 1'b1, vidx: idx,
                             gold: ksa2_golden(vec[1:0], vec[3:2], vec[4])};
            end else begin
                {cin_Pad, b1_Pad, b0_Pad, a1_Pad, a0_Pad} <= '0;
                pipe[0] <= '0;
            end

            // err_count never returns to 0 once it leaves it, so it doubles as
            // the "first mismatch not yet seen" flag.
            err_count <= err_next;
            if (mismatch && err_count == 8'd0) begin
                first_err_idx <= pipe[DEPTH].vidx;
                first_err_got <= resp;
                first_err_exp <= pipe[DEPTH].gold;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q        <= mode;
                        num_vec_q     <= num_vec;
                        idx           <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        first_err_got <= '0;
                        first_err_exp <= '0;
                        if (num_vec == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            pass  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    idx <= idx + NVEC_W'(1);
                    if (idx == num_vec_q - NVEC_W'(1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_W'(DEPTH);
                    end
                end
                ST_DRAIN: begin
                    // DEPTH+1 drain cycles: the last vector sits on the pads one
                    // cycle after it is decided, then needs DEPTH more cycles.
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'd0);
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa2_pulse_tester.sv
// Bench for ksa2_pulse_tester: a behavioural adder (with selectable faults)
// answers on the pads, and each run is compared with a vector-level model.
module tb_ksa2_pulse_tester;

    localparam int DEPTH  = 4;
    localparam int NVEC_W = 8;

    localparam int F_IDEAL = 0;
    localparam int F_STUCK = 1;
    localparam int F_LATE  = 2;
    localparam int F_INV   = 3;

    logic              GCLK = 1'b0;
    logic              RST  = 1'b1;
    logic              start = 1'b0;
    logic              mode  = 1'b0;
    logic [NVEC_W-1:0] num_vec = '0;
    logic              a0_Pad, a1_Pad, b0_Pad, b1_Pad, cin_Pad;
    logic              sum0_Pad, sum1_Pad, cout_Pad;
    logic              busy, done, pass;
    logic [7:0]        err_count;
    logic [NVEC_W-1:0] first_err_idx;
    logic [2:0]        first_err_got, first_err_exp;

    int errors = 0;
    int checks = 0;
    int fault  = F_IDEAL;

    logic [2:0] dly [DEPTH+1] = '{default: 3'b000};
    logic [2:0] resp;

    always #5 GCLK = ~GCLK;

    ksa2_pulse_tester #(
        .DEPTH  (DEPTH),
        .NVEC_W (NVEC_W)
    ) dut (
        .GCLK          (GCLK),
        .RST           (RST),
        .start         (start),
        .mode          (mode),
        .num_vec       (num_vec),
        .a0_Pad        (a0_Pad),
        .a1_Pad        (a1_Pad),
        .b0_Pad        (b0_Pad),
        .b1_Pad        (b1_Pad),
        .cin_Pad       (cin_Pad),
        .sum0_Pad      (sum0_Pad),
        .sum1_Pad      (sum1_Pad),
        .cout_Pad      (cout_Pad),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp)
    );

    function automatic logic [2:0] gold(input logic [4:0] v);
        int s;
        s = int'(v[1:0]) + int'(v[3:2]) + int'(v[4]);
        return 3'(s);
    endfunction

    // Behavioural adder: DEPTH clocked stages from pads to outputs.
    always @(posedge GCLK) begin
        dly[0] <= gold({cin_Pad, b1_Pad, b0_Pad, a1_Pad, a0_Pad});
        for (int i = 1; i <= DEPTH; i++) dly[i] <= dly[i-1];
    end

    always_comb begin
        resp = dly[DEPTH-1];
        case (fault)
            F_STUCK: resp = dly[DEPTH-1] & 3'b101;
            F_LATE:  resp = dly[DEPTH];
            F_INV:   resp = ~dly[DEPTH-1];
            default: resp = dly[DEPTH-1];
        endcase
    end
    assign {cout_Pad, sum1_Pad, sum0_Pad} = resp;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_pads"}, {cin_Pad, b1_Pad, b0_Pad, a1_Pad, a0_Pad}, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_pass"}, pass, 0);
        check_val({tag, "_err_count"}, err_count, 0);
        check_val({tag, "_first_idx"}, first_err_idx, 0);
        check_val({tag, "_first_got"}, first_err_got, 0);
        check_val({tag, "_first_exp"}, first_err_exp, 0);
    endtask

    // One complete run: build the vector list from the source rules, predict
    // what the faulty/ideal adder returns per vector, then drive and observe.
    task automatic run_test(input logic m, input int n, input int flt,
                            input int restart_at, input string tag);
        logic [4:0] vecs[$];
        logic [7:0] s;
        logic [2:0] e, g, prev_e;
        int exp_err, exp_fidx, exp_fgot, exp_fexp;
        int c, busy_cnt, done_c, pad_bad, exp_len;
        bit done_seen;

        s = 8'hA5;
        for (int i = 0; i < n; i++) begin
            if (m) vecs.push_back(s[4:0]);
            else   vecs.push_back(5'(i % 32));
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end

        exp_err = 0; exp_fidx = 0; exp_fgot = 0; exp_fexp = 0;
        prev_e = 3'b000;
        for (int i = 0; i < n; i++) begin
            e = gold(vecs[i]);
            case (flt)
                F_STUCK: g = e & 3'b101;
                F_LATE:  g = prev_e;
                F_INV:   g = ~e;
                default: g = e;
            endcase
            prev_e = e;
            if (g != e) begin
                if (exp_err == 0) begin
                    exp_fidx = i; exp_fgot = int'(g); exp_fexp = int'(e);
                end
                exp_err++;
            end
        end
        if (exp_err > 255) exp_err = 255;
        exp_len = (n == 0) ? 0 : n + DEPTH + 1;

        fault = flt;
        @(negedge GCLK);
        mode = m; num_vec = NVEC_W'(n); start = 1'b1;
        @(negedge GCLK);
        start = 1'b0;

        c = 0; busy_cnt = 0; done_c = -1; pad_bad = 0; done_seen = 0;
        while (!done_seen && c < n + DEPTH + 20) begin
            if (busy) busy_cnt++;
            if (c >= 1 && c <= n && {cin_Pad, b1_Pad, b0_Pad, a1_Pad, a0_Pad} !== vecs[c-1])
                pad_bad++;
            if (done) begin
                done_seen = 1;
                done_c = c;
            end
            if (c == restart_at) begin
                start = 1'b1; mode = ~m; num_vec = NVEC_W'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge GCLK);
            c++;
        end
        start = 1'b0;

        check_val({tag, "_done_seen"}, done_seen, 1);
        check_val({tag, "_busy_cycles"}, busy_cnt, exp_len);
        check_val({tag, "_done_cycle"}, done_c, exp_len);
        check_val({tag, "_pad_vectors_bad"}, pad_bad, 0);
        check_val({tag, "_done_width"}, done, 0);
        check_val({tag, "_busy_after"}, busy, 0);
        check_val({tag, "_err_count"}, err_count, exp_err);
        check_val({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
        check_val({tag, "_first_idx"}, first_err_idx, exp_fidx);
        check_val({tag, "_first_got"}, first_err_got, exp_fgot);
        check_val({tag, "_first_exp"}, first_err_exp, exp_fexp);
    endtask

    initial begin
        repeat (3) @(negedge GCLK);
        check_val("in_reset_busy", busy, 0);
        RST = 1'b0;
        @(negedge GCLK);
        check_reset_state("reset");

        run_test(1'b0, 32, F_IDEAL, -1, "exh32_ideal");

        run_test(1'b0, 32, F_STUCK, -1, "exh32_stuck");
        check_val("stuck_const_err", err_count, 16);
        check_val("stuck_const_idx", first_err_idx, 2);
        check_val("stuck_const_got", first_err_got, 3'b000);
        check_val("stuck_const_exp", first_err_exp, 3'b010);

        run_test(1'b0, 32, F_LATE, -1, "exh32_late");
        check_val("late_const_idx", first_err_idx, 1);
        check_val("late_const_nonzero", (err_count > 0) ? 1 : 0, 1);

        run_test(1'b0, 0, F_IDEAL, -1, "nvec0");

        // Abort a faulty run mid-way; everything must return to reset values.
        fault = F_STUCK;
        @(negedge GCLK);
        mode = 1'b0; num_vec = NVEC_W'(32); start = 1'b1;
        @(negedge GCLK);
        start = 1'b0;
        repeat (10) @(negedge GCLK);
        check_val("abort_pre_busy", busy, 1);
        check_val("abort_pre_err_seen", (err_count != 0) ? 1 : 0, 1);
        RST = 1'b1;
        #2;
        check_reset_state("abort_async");
        @(negedge GCLK);
        RST = 1'b0;
        fault = F_IDEAL;
        @(negedge GCLK);
        check_reset_state("abort_after");
        run_test(1'b0, 32, F_IDEAL, -1, "post_abort");

        run_test(1'b1, 255, F_IDEAL, 20, "lfsr255_restart");

        run_test(1'b0, 40, F_IDEAL, -1, "exh40_wrap");

        for (int k = 0; k < 6; k++)
            run_test(1'($urandom_range(0, 1)), int'($urandom_range(1, 80)),
                     int'($urandom_range(0, 3)), -1, $sformatf("rand%0d", k));

        run_test(1'b1, 255, F_INV, -1, "lfsr255_inv");
        run_test(1'b0, 0, F_IDEAL, -1, "nvec0_from_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
